// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared FSM/grant types and line-address constants for the memory arbiter
package mem_arb_pkg;
  localparam int LINE_OFF_BITS = 6;
  localparam int LINE_TAG_LSB = 6;
  typedef enum logic [2:0] {IDLE, WR, RD_I, RD_D, RESP} state_t;
  typedef enum logic {ICACHE, DCACHE} grant_t;
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: cache-side and memory-side signals of the memory arbiter
interface mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINE_W = 512
);
  logic i_req, i_done, d_req, d_done, w_req, w_done;
  logic mem_valid, mem_we, mem_ready;
  logic [ADDR_W-1:0] i_addr, d_addr, w_addr, mem_addr;
  logic [DATA_W-1:0] w_data, mem_wdata;
  logic [LINE_W-1:0] i_rdata, d_rdata, mem_rdata;
  modport slave (
    input i_req, i_addr, d_req, d_addr, w_req, w_addr, w_data, mem_ready, mem_rdata,
    output i_rdata, i_done, d_rdata, d_done, w_done, mem_valid, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output i_req, i_addr, d_req, d_addr, w_req, w_addr, w_data, mem_ready, mem_rdata,
    input i_rdata, i_done, d_rdata, d_done, w_done, mem_valid, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_write_buffer.sv
// mem_write_buffer: posted-store FIFO with a parallel line-address match over valid entries
module mem_write_buffer import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic push,
  input  logic pop,
  input  logic [ADDR_W-1:0] push_addr,
  input  logic [DATA_W-1:0] push_data,
  input  logic [ADDR_W-1:LINE_TAG_LSB] match_tag,
  output logic full,
  output logic empty,
  output logic [ADDR_W-1:0] head_addr,
  output logic [DATA_W-1:0] head_data,
  output logic [DEPTH-1:0] match
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wr_ptr, rd_ptr, count;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  assign count = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  assign full = wr_ptr == {~rd_ptr[AW], rd_ptr[AW-1:0]};
  assign head_addr = addr_q[rd_ptr[AW-1:0]];
  assign head_data = data_q[rd_ptr[AW-1:0]];
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  always_ff @(posedge clk)
    if (push) begin
      addr_q[wr_ptr[AW-1:0]] <= push_addr;
      data_q[wr_ptr[AW-1:0]] <= push_data;
    end
  // a slot is live when its distance from the head is below the occupancy
  for (genvar k = 0; k < DEPTH; k++) begin : g_match
    logic [AW-1:0] off;
    assign off = AW'(k) - rd_ptr[AW-1:0];
    assign match[k] = ({1'b0, off} < count) && addr_q[k][ADDR_W-1:LINE_TAG_LSB] == match_tag;
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: serialises icache/dcache line refills and posted dcache stores onto one memory port
module mem_arbiter import mem_arb_pkg::*; #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int WBUF_DEPTH = 4
) (
  input logic clk,
  input logic rst,
  mem_arbiter_if.slave bus
);
  state_t state, state_n;
  grant_t last_rd_grant;
  logic full, empty, push, pop, hazard;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic [WBUF_DEPTH-1:0] match;
  assign pop = state == WR && bus.mem_ready;
  assign push = bus.w_req && !bus.w_done && (!full || pop);
  assign hazard = bus.d_req && |match;
  mem_write_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(WBUF_DEPTH)) u_wbuf (
    .clk(clk),
    .rst(rst),
    .push(push),
    .pop(pop),
    .push_addr(bus.w_addr),
    .push_data(bus.w_data),
    .match_tag(bus.d_addr[ADDR_W-1:LINE_TAG_LSB]),
    .full(full),
    .empty(empty),
    .head_addr(head_addr),
    .head_data(head_data),
    .match(match)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      last_rd_grant <= ICACHE;
      bus.i_done <= 1'b0;
      bus.d_done <= 1'b0;
      bus.w_done <= 1'b0;
      bus.i_rdata <= '0;
      bus.d_rdata <= '0;
    end else begin
      state <= state_n;
      bus.i_done <= state == RD_I && bus.mem_ready;
      bus.d_done <= state == RD_D && bus.mem_ready;
      bus.w_done <= push;
      if (state == RD_I && bus.mem_ready) begin
        bus.i_rdata <= bus.mem_rdata;
        last_rd_grant <= ICACHE;
      end
      if (state == RD_D && bus.mem_ready) begin
        bus.d_rdata <= bus.mem_rdata;
        last_rd_grant <= DCACHE;
      end
    end
  // draining stores wins over reads when the buffer is full or a dcache read would bypass a pending store
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = full || hazard || (!empty && !bus.i_req && !bus.d_req) ? WR
                    : bus.d_req && bus.i_req ? (last_rd_grant == ICACHE ? RD_D : RD_I)
                    : bus.d_req ? RD_D
                    : bus.i_req ? RD_I : IDLE;
      WR: state_n = bus.mem_ready ? IDLE : WR;
      RD_I, RD_D: state_n = bus.mem_ready ? RESP : state;
      RESP: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign bus.mem_valid = state == WR || state == RD_I || state == RD_D;
  assign bus.mem_we = state == WR;
  assign bus.mem_wdata = state == WR ? head_data : '0;
  assign bus.mem_addr = state == WR ? head_addr
                      : state == RD_I ? {bus.i_addr[ADDR_W-1:LINE_TAG_LSB], {LINE_OFF_BITS{1'b0}}}
                      : state == RD_D ? {bus.d_addr[ADDR_W-1:LINE_TAG_LSB], {LINE_OFF_BITS{1'b0}}}
                      : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized checks of mem_arbiter against a store-queue memory model
module tb_mem_arbiter;
  localparam int LINE_W = 512;
  typedef struct packed {logic [31:0] addr; logic [31:0] data;} st_t;
  logic clk = 0;
  logic rst = 1;
  always #5 clk = ~clk;
  mem_arbiter_if bus();
  mem_arbiter dut(.clk(clk), .rst(rst), .bus(bus));
  int n_chk = 0;
  int n_bad = 0;
  // accepted stores in acceptance order; entries from wr_seen on have not reached memory yet
  st_t pend[$];
  int wr_seen = 0;
  logic [32:0] log_q[$];
  int lat_mode = 0;
  logic stall = 0;
  logic busy = 0;
  int lat = 0;
  int n_hit;
  logic t_we;
  logic [31:0] t_addr, t_wdata;
  int b;

  task automatic check(input string tag, input logic [LINE_W-1:0] got, input logic [LINE_W-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] pat(input logic [31:0] a);
    for (int k = 0; k < 16; k++) pat[k*32 +: 32] = a ^ (32'(k) * 32'h0101_0101) ^ 32'h5A00_0000;
  endfunction

  function automatic logic [31:0] line_of(input logic [31:0] a);
    return {a[31:6], 6'b0};
  endfunction

  // memory: random or fixed latency, holds off while stall is set, checks order and stability
  always @(negedge clk) begin
    if (rst) begin
      bus.mem_ready = 0;
      busy = 0;
    end else if (bus.mem_ready) begin
      bus.mem_ready = 0;
      busy = 0;
    end else if (bus.mem_valid) begin
      if (!busy) begin
        busy = 1;
        t_we = bus.mem_we;
        t_addr = bus.mem_addr;
        t_wdata = bus.mem_wdata;
        lat = lat_mode < 0 ? int'($urandom_range(0, 3)) : lat_mode;
        log_q.push_back({t_we, t_addr});
        if (!t_we) begin
          check("rd_align", t_addr[5:0], 0);
          if (t_addr >= 32'h1_0000) begin
            n_hit = 0;
            for (int j = wr_seen; j < pend.size(); j++) if (line_of(pend[j].addr) == t_addr) n_hit++;
            check("raw_order", n_hit, 0);
          end
        end
      end else begin
        check("hold_addr", bus.mem_addr, t_addr);
        check("hold_we", bus.mem_we, t_we);
        check("hold_wdata", bus.mem_wdata, t_wdata);
      end
      if (!stall) begin
        if (lat == 0) begin
          bus.mem_ready = 1;
          bus.mem_rdata = pat(t_addr);
          if (t_we) begin
            if (wr_seen >= pend.size()) check("wr_unexpected", 1, 0);
            else begin
              check("wr_addr", t_addr, pend[wr_seen].addr);
              check("wr_data", t_wdata, pend[wr_seen].data);
            end
            wr_seen++;
          end
        end else lat--;
      end
    end
  end

  task automatic refill(input bit d, input logic [31:0] a);
    int t = 0;
    if (d) begin bus.d_addr = a; bus.d_req = 1; end
    else begin bus.i_addr = a; bus.i_req = 1; end
    do begin @(negedge clk); t++; end while (!(d ? bus.d_done : bus.i_done) && t < 400);
    check(d ? "d_done" : "i_done", d ? bus.d_done : bus.i_done, 1);
    check(d ? "d_rdata" : "i_rdata", d ? bus.d_rdata : bus.i_rdata, pat(line_of(a)));
    if (d) bus.d_req = 0;
    else bus.i_req = 0;
    @(negedge clk);
    check(d ? "d_pulse" : "i_pulse", d ? bus.d_done : bus.i_done, 0);
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] v);
    int t = 0;
    bus.w_addr = a;
    bus.w_data = v;
    bus.w_req = 1;
    do begin @(negedge clk); t++; end while (!bus.w_done && t < 400);
    check("w_done", bus.w_done, 1);
    if (bus.w_done) pend.push_back(st_t'({a, v}));
    bus.w_req = 0;
  endtask

  task automatic drain();
    int t = 0;
    while (wr_seen != pend.size() && t < 400) begin @(negedge clk); t++; end
    check("drain", wr_seen, pend.size());
  endtask

  initial begin
    bus.i_req = 0; bus.d_req = 0; bus.w_req = 0;
    bus.i_addr = 0; bus.d_addr = 0; bus.w_addr = 0; bus.w_data = 0;
    repeat (3) @(negedge clk);
    check("rst_ctl", {bus.mem_valid, bus.mem_we, bus.i_done, bus.d_done, bus.w_done}, 0);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_mem_wdata", bus.mem_wdata, 0);
    check("rst_rdata", {bus.i_rdata, bus.d_rdata}, 0);
    rst = 0;
    @(negedge clk);
    // contention straight after reset: dcache first since the last grant resets to icache
    b = log_q.size();
    fork
      refill(0, 32'h0000_0400);
      refill(1, 32'h0001_0800);
    join
    check("cont_first", log_q[b], {1'b0, 32'h0001_0800});
    check("cont_second", log_q[b+1], {1'b0, 32'h0000_0400});
    lat_mode = 3;
    b = log_q.size();
    refill(0, 32'h0000_1234);
    check("i_line_addr", log_q[b], {1'b0, 32'h0000_1200});
    lat_mode = 0;
    bus.i_addr = 32'h0000_0040;
    bus.i_req = 1;
    @(negedge clk);
    check("lat_valid", bus.mem_valid, 1);
    @(negedge clk);
    check("lat_done", bus.i_done, 1);
    bus.i_req = 0;
    @(negedge clk);
    // posting with memory stalled: four stores fit, the fifth waits
    stall = 1;
    b = log_q.size();
    for (int k = 0; k < 4; k++) store(32'h100 + 32'(4 * k), $urandom);
    bus.w_addr = 32'h110;
    bus.w_data = 32'h5555_0005;
    bus.w_req = 1;
    repeat (4) begin @(negedge clk); check("w_stall", bus.w_done, 0); end
    stall = 0;
    store(32'h110, 32'h5555_0005);
    drain();
    for (int k = 0; k < 5; k++) check("post_order", log_q[b+k], {1'b1, 32'h100 + 32'(4 * k)});
    b = log_q.size();
    store(32'h2040, 32'hDEAD_BEEF);
    refill(1, 32'h2044);
    check("raw_wr_first", log_q[b], {1'b1, 32'h2040});
    check("raw_rd_second", log_q[b+1], {1'b0, 32'h2040});
    b = log_q.size();
    store(32'h3000, 32'h0BAD_F00D);
    refill(1, 32'h5000);
    drain();
    check("byp_rd_first", log_q[b], {1'b0, 32'h5000});
    check("byp_wr_second", log_q[b+1], {1'b1, 32'h3000});
    // reset in the middle of a stalled dcache read with a store still buffered
    stall = 1;
    bus.d_addr = 32'h6000;
    bus.d_req = 1;
    store(32'h7000, 32'h1234_5678);
    check("mid_valid", bus.mem_valid, 1);
    rst = 1;
    #1;
    check("rst_async_valid", bus.mem_valid, 0);
    check("rst_async_done", {bus.i_done, bus.d_done, bus.w_done}, 0);
    bus.d_req = 0;
    stall = 0;
    void'(pend.pop_back());
    @(negedge clk);
    check("rst_d_rdata", bus.d_rdata, 0);
    rst = 0;
    repeat (6) begin @(negedge clk); check("rst_buf_empty", bus.mem_valid, 0); end
    lat_mode = -1;
    fork
      repeat (60) begin
        repeat ($urandom_range(0, 6)) @(negedge clk);
        refill(0, $urandom_range(0, 32'hFFF));
      end
      begin : g_dproc
        logic [31:0] a;
        repeat (150) begin
          a = 32'h1_0000 + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 15) << 2);
          repeat ($urandom_range(0, 3)) @(negedge clk);
          if ($urandom_range(0, 2) == 0) refill(1, a);
          else store(a, $urandom);
        end
      end
    join
    drain();
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
